// File: rtl/power_dispatch.sv
// Multi-motor power dispatcher: one shared restoring divider, saturated per-motor outputs, tick
// watchdog. Define HAMSTER_PWR_SLEW_EN to add per-tick slew limiting of o_pwr toward its target.
module power_dispatch #(
  parameter int K_NMOT    = 2,
  parameter int K_RES     = 8,
  parameter int K_OUTRES  = 4,
  parameter int K_WDT_RES = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [K_RES-1:0]            i_power,
  input  logic [K_NMOT*K_RES-1:0]     i_div,
  input  logic                        i_tick,
  input  logic [K_WDT_RES-1:0]        i_wdt_thr,
  input  logic [K_OUTRES-1:0]         i_slew_step,
  output logic [K_NMOT*K_OUTRES-1:0]  o_pwr,
  output logic [K_NMOT-1:0]           o_valid,
  output logic [K_NMOT-1:0]           o_dbz,
  output logic                        o_busy,
  output logic                        o_timeout
);
  localparam int IDXW = (K_NMOT > 1) ? $clog2(K_NMOT) : 1;
  localparam int BITW = (K_RES > 1) ? $clog2(K_RES) : 1;
  localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(K_NMOT - 1);
  localparam logic [BITW-1:0]     LAST_BIT = BITW'(K_RES - 1);
  localparam logic [K_OUTRES-1:0] OUT_MAX  = '1;

  typedef enum logic [1:0] {StIdle, StDiv, StStore} state_e;

  state_e r_state, w_state_next;

  logic [K_RES-1:0]        r_pwr_snap, r_pend_pwr;
  logic [K_NMOT*K_RES-1:0] r_div_snap, r_pend_div;
  logic                    r_pend;
  logic [IDXW-1:0]         r_idx;
  logic [BITW-1:0]         r_bit;
  logic [K_RES-1:0]        r_num, r_rem;
  logic [K_RES-2:0]        r_quo;
  logic [K_WDT_RES-1:0]    r_wdt;
  logic                    r_timeout;
  logic [K_OUTRES-1:0]     r_pwr [K_NMOT];
  logic [K_NMOT-1:0]       r_valid, r_dbz;

  logic [K_RES-1:0]     w_div_arr [K_NMOT];
  logic [K_RES-1:0]     w_div_cur, w_rem_sub, w_quo_full;
  logic [K_RES:0]       w_trial;
  logic                 w_ge, w_dbz, w_sat;
  logic [K_OUTRES-1:0]  w_q_out;
  logic                 w_seq_start, w_next_motor, w_store, w_store_ok, w_expire;
  logic [K_WDT_RES-1:0] w_wdt_inc;

  always_comb begin
    w_div_arr = '{default: '0};
    for (int m = 0; m < K_NMOT; m++) w_div_arr[m] = r_div_snap[m*K_RES +: K_RES];
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_div_cur  = w_div_arr[r_idx];
  assign w_trial    = {r_rem, r_num[K_RES-1]};
  assign w_ge       = (w_trial >= {1'b0, w_div_cur});
  assign w_rem_sub  = w_trial[K_RES-1:0] - w_div_cur;
  assign w_quo_full = {r_quo, w_ge};
  assign w_sat      = |(w_quo_full >> K_OUTRES);
  assign w_q_out    = w_sat ? OUT_MAX : w_quo_full[K_OUTRES-1:0];
  assign w_dbz      = (w_div_cur == '0);

  assign w_seq_start  = ((r_state == StIdle) && i_start) ||
                        ((r_state == StStore) && (r_idx == LAST_IDX) && (r_pend || i_start));
  assign w_next_motor = (r_state == StStore) && (r_idx != LAST_IDX);
  assign w_store      = (r_state == StDiv) && (r_bit == LAST_BIT);
  assign w_store_ok   = w_store && !r_timeout;

  assign w_wdt_inc = r_wdt + 1'b1;
  assign w_expire  = i_tick && !i_start && (i_wdt_thr != '0) && (r_wdt < i_wdt_thr) &&
                     (w_wdt_inc == i_wdt_thr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StDiv;
      StDiv:   if (r_bit == LAST_BIT) w_state_next = StStore;
      StStore: w_state_next = (w_seq_start || w_next_motor) ? StDiv : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwr_snap <= '0;
      r_div_snap <= '0;
      r_pend_pwr <= '0;
      r_pend_div <= '0;
      r_pend     <= 1'b0;
      r_idx      <= '0;
      r_bit      <= '0;
      r_num      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
    end else begin
      if (w_seq_start) begin
        // A start in the final STORE is newer than any pending snapshot.
        r_pwr_snap <= i_start ? i_power : r_pend_pwr;
        r_div_snap <= i_start ? i_div : r_pend_div;
        r_num      <= i_start ? i_power : r_pend_pwr;
        r_idx      <= '0;
        r_bit      <= '0;
        r_rem      <= '0;
        r_quo      <= '0;
      end else if (w_next_motor) begin
        r_num <= r_pwr_snap;
        r_idx <= r_idx + 1'b1;
        r_bit <= '0;
        r_rem <= '0;
        r_quo <= '0;
      end else if (r_state == StDiv) begin
        r_num <= {r_num[K_RES-2:0], 1'b0};
        r_rem <= w_ge ? w_rem_sub : w_trial[K_RES-1:0];
        r_quo <= w_quo_full[K_RES-2:0];
        r_bit <= r_bit + 1'b1;
      end

      if (w_seq_start) begin
        r_pend <= 1'b0;
      end else if (i_start) begin
        r_pend     <= 1'b1;
        r_pend_pwr <= i_power;
        r_pend_div <= i_div;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_start) begin
      r_wdt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_tick && (i_wdt_thr != '0) && (r_wdt < i_wdt_thr)) begin
      r_wdt <= w_wdt_inc;
      if (w_expire) r_timeout <= 1'b1;
    end
  end

`ifdef HAMSTER_PWR_SLEW_EN
  logic [K_OUTRES-1:0] r_target [K_NMOT];
  logic [K_OUTRES-1:0] w_slew   [K_NMOT];

  function automatic logic [K_OUTRES-1:0] slew_to(input logic [K_OUTRES-1:0] cur,
                                                  input logic [K_OUTRES-1:0] tgt,
                                                  input logic [K_OUTRES-1:0] step);
    if (tgt > cur)      return ((tgt - cur) > step) ? cur + step : tgt;
    else if (tgt < cur) return ((cur - tgt) > step) ? cur - step : tgt;
    else                return cur;
  endfunction

  always_comb begin
    w_slew = '{default: '0};
    for (int m = 0; m < K_NMOT; m++) w_slew[m] = slew_to(r_pwr[m], r_target[m], i_slew_step);
  end
`else
  logic w_unused_slew;
  assign w_unused_slew = ^i_slew_step;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int m = 0; m < K_NMOT; m++) begin
        r_pwr[m] <= '0;
`ifdef HAMSTER_PWR_SLEW_EN
        r_target[m] <= '0;
`endif
      end
      r_valid <= '0;
      r_dbz   <= '0;
    end else begin
      r_valid <= '0;
      if (w_expire) begin
        for (int m = 0; m < K_NMOT; m++) begin
          if (r_pwr[m] != '0) r_valid[m] <= 1'b1;
          r_pwr[m] <= '0;
`ifdef HAMSTER_PWR_SLEW_EN
          r_target[m] <= '0;
`endif
        end
      end else begin
`ifdef HAMSTER_PWR_SLEW_EN
        if (i_tick) begin
          for (int m = 0; m < K_NMOT; m++) begin
            if (w_slew[m] != r_pwr[m]) begin
              r_pwr[m]   <= w_slew[m];
              r_valid[m] <= 1'b1;
            end
          end
        end
        if (w_store_ok) begin
          r_target[r_idx] <= w_q_out;
          r_dbz[r_idx]    <= w_dbz;
          if (i_slew_step == '0) begin
            r_pwr[r_idx]   <= w_q_out;
            r_valid[r_idx] <= 1'b1;
          end
        end
`else
        if (w_store_ok) begin
          r_pwr[r_idx]   <= w_q_out;
          r_valid[r_idx] <= 1'b1;
          r_dbz[r_idx]   <= w_dbz;
        end
`endif
      end
    end
  end

  always_comb begin
    o_pwr = '0;
    for (int m = 0; m < K_NMOT; m++) o_pwr[m*K_OUTRES +: K_OUTRES] = r_pwr[m];
  end

  assign o_valid   = r_valid;
  assign o_dbz     = r_dbz;
  assign o_busy    = (r_state != StIdle);
  assign o_timeout = r_timeout;

endmodule

// File: doc/power_dispatch.md
# power_dispatch

Parametrised power-command dispatcher placed between the radio channel decoder and the motor controllers. It generalises the single shared power divider to K_NMOT motors, each with its own register-bank divisor. Each motor gets a saturated, optionally slew-limited power command. One restoring divider is time-multiplexed across motors, and a tick-based watchdog forces all outputs to zero when radio commands stop arriving.

## Interface
- K_NMOT, 2, number of motors served
- K_RES, 8, width of input power and divisors
- K_OUTRES, 4, width of per-motor power output
- K_WDT_RES, 8, watchdog counter width
- i_clk  in  1  main clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle strobe: new i_power sample available
- i_power  in  K_RES  unsigned power command
- i_div  in  K_NMOT×K_RES  packed per-motor unsigned divisors, motor m at [m]
- i_tick  in  1  timebase tick (watchdog and slew pacing)
- i_wdt_thr  in  K_WDT_RES  watchdog timeout in ticks; 0 disables
- i_slew_step  in  K_OUTRES  max output change per tick (used only with slew macro)
- o_pwr  out  K_NMOT×K_OUTRES  per-motor power command
- o_valid  out  K_NMOT  one-cycle strobe when o_pwr[m] changes or is rewritten
- o_dbz  out  K_NMOT  divisor of last update of motor m was zero
- o_busy  out  1  divider sequence in progress
- o_timeout  out  1  watchdog expired

## Operation
- FSM states: IDLE, DIV, STORE.
- IDLE + i_start: snapshot i_power and all i_div. Set idx=0, bit counter=0, go to DIV.
- DIV: one restoring-division quotient bit per cycle, MSB first, K_RES cycles, then go to STORE.
- STORE: write target[idx] and o_dbz[idx].
  - If idx=K_NMOT-1, go to IDLE (or straight to DIV if a start is pending).
  - Otherwise idx++ and go to DIV.
- Saturation: quotient > 2^K_OUTRES−1 gives all-ones.
- Divisor 0: still takes K_RES cycles. Result is all-ones and o_dbz[idx]=1. o_dbz holds until that motor's next STORE.
- i_start while busy: set a one-deep pending flag and overwrite a pending i_power/i_div snapshot (last value wins). After the final STORE, restart with that snapshot without passing through IDLE.
- Watchdog: counts i_tick since the last i_start and saturates at i_wdt_thr.
  - On reaching a nonzero i_wdt_thr: o_timeout=1, every o_pwr and target is cleared to 0, and o_valid pulses on every motor whose o_pwr was nonzero.
  - Any i_start clears the counter and o_timeout.
  - While o_timeout=1, a STORE completing from a sequence started before expiry is discarded.
- Reset values: o_pwr=0, o_valid=0, o_dbz=0, o_busy=0, o_timeout=0, FSM=IDLE, pending=0, counters=0. Asynchronous reset mid-sequence aborts the sequence with no valid pulse.

## Timing
- i_start sampled in cycle 0.
- o_busy is high from cycle 1 through cycle K_NMOT·(K_RES+1).
- o_valid[m] (without slew) is high in cycle m·(K_RES+1)+K_RES+1.
  - Default parameters: motor 0 at cycle 9, motor 1 at cycle 18.
  - IDLE again at cycle 19, when a new i_start is accepted.
- o_pwr[m] updates in the same cycle as its o_valid[m], registered.
- o_timeout rises the cycle after the expiring i_tick; outputs clear in that same cycle.
- o_timeout falls the cycle after i_start.
- i_tick and i_start in the same cycle: i_start wins, and the counter resets to 0.

## Configuration
- HAMSTER_PWR_SLEW_EN defined:
  - STORE updates the internal target only.
  - On each i_tick, o_pwr[m] moves toward target[m] by at most i_slew_step (clamped, no overshoot). o_valid[m] pulses on each change.
  - i_slew_step=0 means no limiting: o_pwr follows target at STORE.
  - Timeout clear is immediate and bypasses slew.
- Undefined: no slew logic or target/output split. o_pwr is written directly at STORE; i_slew_step is unused.

## Test plan
- Defaults, i_power=200, i_div={20,50}, i_start at cycle 0 → o_pwr[0]=10 with o_valid[0] at cycle 9; o_pwr[1]=4 with o_valid[1] at cycle 18; o_busy low at cycle 19.
- i_power=255, i_div[0]=1 → o_pwr[0]=15 (saturated), o_dbz[0]=0. i_div[1]=0 → o_pwr[1]=15, o_dbz[1]=1.
- Second i_start at cycle 5 with i_power=100 → first results at cycles 9/18, then the second sequence with no idle gap, results at cycles 27/36.
- i_wdt_thr=3, no i_start after the first sequence, 3 i_ticks → o_timeout=1, o_pwr all 0, o_valid pulse on nonzero motors. Next i_start clears o_timeout.
- With HAMSTER_PWR_SLEW_EN, i_slew_step=2, target 0→10 → o_pwr steps 2,4,6,8,10 on consecutive ticks.
- Assert i_rst_n low at cycle 4 of a sequence → all outputs 0 immediately. After release, a fresh i_start completes normally.
